add_serial: RTL and testbench

ADD_SERIAL -- requirements
Module: add_serial

---
 rtl/add_serial.sv | 154 +++++++++++++++
 tb/tb_add_serial.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// ============================================================================
// Module   : add_serial
// Brief    : Bit-serial sign-magnitude adder, one magnitude bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_serial #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_out,
    output logic         o_carry
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(N - 2);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_PREP = 2'd1,
        c_CALC = 2'd2,
        c_DONE = 2'd3
    } state_t;

    state_t         r_state_q, w_state_d;
    logic [N-1:0]   r_a_q, w_a_d;
    logic [N-1:0]   r_b_q, w_b_d;
    logic [N-2:0]   r_res_q, w_res_d;
    logic [CW-1:0]  r_cnt_q, w_cnt_d;
    logic           r_cy_q, w_cy_d;
    logic           r_sub_q, w_sub_d;
    logic           r_sign_q, w_sign_d;
    logic [N-1:0]   r_out_q, w_out_d;
    logic           r_carry_q, w_carry_d;
    logic           r_done_q, w_done_d;
    logic           r_busy_q, w_busy_d;

    logic           w_bit;
    logic           w_cy_next;

    // In subtract mode r_a_q holds the larger magnitude, so the borrow never escapes
    always_comb begin
        w_bit     = r_a_q[0] ^ r_b_q[0] ^ r_cy_q;
        w_cy_next = r_sub_q ? ((~r_a_q[0] & r_b_q[0]) | (~(r_a_q[0] ^ r_b_q[0]) & r_cy_q))
                            : ((r_a_q[0] & r_b_q[0]) | ((r_a_q[0] ^ r_b_q[0]) & r_cy_q));
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_cnt_d   = r_cnt_q;
        w_cy_d    = r_cy_q;
        w_sub_d   = r_sub_q;
        w_sign_d  = r_sign_q;
        w_out_d   = r_out_q;
        w_carry_d = r_carry_q;

        case (r_state_q)
            c_IDLE: begin
                if (i_start) begin
                    w_a_d     = i_a;
                    w_b_d     = i_b;
                    w_state_d = c_PREP;
                end
            end
            c_PREP: begin
                w_sub_d = r_a_q[N-1] ^ r_b_q[N-1];
                if (!w_sub_d) begin
                    w_sign_d = r_a_q[N-1];
                end else if (r_a_q[N-2:0] > r_b_q[N-2:0]) begin
                    w_sign_d = r_a_q[N-1];
                end else if (r_b_q[N-2:0] > r_a_q[N-2:0]) begin
                    w_sign_d       = r_b_q[N-1];
                    w_a_d[N-2:0]   = r_b_q[N-2:0];
                    w_b_d[N-2:0]   = r_a_q[N-2:0];
                end else begin
                    w_sign_d = 1'b0;
                end
                w_cy_d    = 1'b0;
                w_cnt_d   = '0;
                w_res_d   = '0;
                w_state_d = c_CALC;
            end
            c_CALC: begin
                w_res_d      = {w_bit, r_res_q[N-2:1]};
                w_a_d[N-2:0] = r_a_q[N-2:0] >> 1;
                w_b_d[N-2:0] = r_b_q[N-2:0] >> 1;
                w_cy_d       = w_cy_next;
                w_cnt_d      = r_cnt_q + CW'(1);
                if (r_cnt_q == c_LAST) begin
                    w_out_d   = {r_sign_q, w_res_d};
                    w_carry_d = r_sub_q ? 1'b0 : w_cy_next;
                    w_state_d = c_DONE;
                end
            end
            c_DONE: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != c_IDLE);
        w_done_d = (w_state_d == c_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= c_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_cnt_q   <= '0;
            r_cy_q    <= 1'b0;
            r_sub_q   <= 1'b0;
            r_sign_q  <= 1'b0;
            r_out_q   <= '0;
            r_carry_q <= 1'b0;
            r_done_q  <= 1'b0;
            r_busy_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_cnt_q   <= w_cnt_d;
            r_cy_q    <= w_cy_d;
            r_sub_q   <= w_sub_d;
            r_sign_q  <= w_sign_d;
            r_out_q   <= w_out_d;
            r_carry_q <= w_carry_d;
            r_done_q  <= w_done_d;
            r_busy_q  <= w_busy_d;
        end
    end

    assign o_busy  = r_busy_q;
    assign o_done  = r_done_q;
    assign o_out   = r_out_q;
    assign o_carry = r_carry_q;

endmodule

`default_nettype wire

// File: tb/tb_add_serial.sv
// ============================================================================
// Module   : tb_add_serial
// Brief    : Self-checking bench for add_serial against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_serial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a, b;
    logic         busy, done, carry;
    logic [N-1:0] out;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] ops_a [0:40];
    logic [N-1:0] ops_b [0:40];

    always #5 clk = ~clk;

    add_serial #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_a     (a),
        .i_b     (b),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .o_out   (out),
        .o_carry (carry)
    );

    // Returns {carry, sign, magnitude} of the sign-magnitude sum x+y
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        int ma, mb, lim, s;
        logic [N:0] r;
        ma  = int'(x[N-2:0]);
        mb  = int'(y[N-2:0]);
        lim = 1 << (N - 1);
        r   = '0;
        if (x[N-1] == y[N-1]) begin
            s          = ma + mb;
            r[N]       = (s >= lim);
            r[N-1]     = x[N-1];
            r[N-2:0]   = (N-1)'(s % lim);
        end else if (ma > mb) begin
            r[N-1]     = x[N-1];
            r[N-2:0]   = (N-1)'(ma - mb);
        end else if (mb > ma) begin
            r[N-1]     = y[N-1];
            r[N-2:0]   = (N-1)'(mb - ma);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        logic [N:0] e;
        e = model(x, y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        chk({tag, ".busy_start"}, 32'(busy), 32'd1);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            chk({tag, ".done_timing"}, 32'(done), 32'(k == N));
            if (k == N) begin
                chk({tag, ".out"},   32'(out),   32'(e[N-1:0]));
                chk({tag, ".carry"}, 32'(carry), 32'(e[N]));
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".done_clear"}, 32'(done), 32'd0);
        chk({tag, ".busy_idle"},  32'(busy), 32'd0);
        chk({tag, ".out_hold"},   32'(out),  32'(e[N-1:0]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out",   32'(out),   32'd0);
        chk("reset.carry", 32'(carry), 32'd0);
        chk("reset.done",  32'(done),  32'd0);
        chk("reset.busy",  32'(busy),  32'd0);

        // start coinciding with reset must be dropped
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h03;
        @(posedge clk);
        #1;
        chk("rst_start.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start.busy2", 32'(busy), 32'd0);

        run_op(8'h05, 8'h03, "add_pos");
        run_op(8'h83, 8'h84, "add_neg");
        run_op(8'h7F, 8'h01, "overflow");
        run_op(8'h05, 8'h89, "sub_b_big");
        run_op(8'h89, 8'h05, "sub_a_big");
        run_op(8'h85, 8'h05, "neg_zero");
        run_op(8'h00, 8'h80, "zeros");
        run_op(8'hFF, 8'hFF, "neg_ovf");

        // abort in the middle of CALC
        @(negedge clk);
        a = 8'h05; b = 8'h03; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort.out",   32'(out),   32'd0);
        chk("abort.carry", 32'(carry), 32'd0);
        chk("abort.done",  32'(done),  32'd0);
        chk("abort.busy",  32'(busy),  32'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("abort.no_done", 32'(done), 32'd0);
        end
        run_op(8'h01, 8'h01, "after_abort");

        // back-to-back with operands changing every cycle
        for (int e = 0; e <= 40; e++) begin
            logic [N:0] m;
            logic       exp_done;
            @(negedge clk);
            a = N'($urandom);
            b = N'($urandom);
            start = 1'b1;
            ops_a[e] = a;
            ops_b[e] = b;
            @(posedge clk);
            #1;
            exp_done = (e >= N) && (((e - N) % (N + 2)) == 0);
            chk("b2b.done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                m = model(ops_a[e-N], ops_b[e-N]);
                chk("b2b.out",   32'(out),   32'(m[N-1:0]));
                chk("b2b.carry", 32'(carry), 32'(m[N]));
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;

        for (int i = 0; i < 30; i++) begin
            run_op(N'($urandom), N'($urandom), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
